// File: rtl/video_pkg.sv
// Shared video constants and the fill-controller state type.
// 1080p60 timing values are shared with the HDMI pixel driver.
package video_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_PREFILL,
        ST_RUN,
        ST_DRAIN
    } fill_state_t;

    localparam int FRAME_WORDS_1080P = 1036800;
    localparam int BYTES_PER_WORD    = 8;

    localparam int H_ACTIVE = 1920;
    localparam int H_FP     = 88;
    localparam int H_SYNC   = 44;
    localparam int H_BP     = 148;
    localparam int H_TOTAL  = 2200;
    localparam int V_ACTIVE = 1080;
    localparam int V_FP     = 4;
    localparam int V_SYNC   = 5;
    localparam int V_BP     = 36;
    localparam int V_TOTAL  = 1125;

endpackage

// File: rtl/pixfifo_fill_ctrl_if.sv
// Avalon-MM burst read bus between the fill controller (master) and SDRAM (slave).
// Command held by the master while waitrequest is high.
interface pixfifo_fill_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] avm_address_o;
    logic              avm_read_o;
    logic [6:0]        avm_burstcount_o;
    logic              avm_waitrequest_i;
    logic [DATA_W-1:0] avm_readdata_i;
    logic              avm_readdatavalid_i;

    modport master (
        output avm_address_o, avm_read_o, avm_burstcount_o,
        input  avm_waitrequest_i, avm_readdata_i, avm_readdatavalid_i
    );

    modport slave (
        input  avm_address_o, avm_read_o, avm_burstcount_o,
        output avm_waitrequest_i, avm_readdata_i, avm_readdatavalid_i
    );
endinterface

// File: rtl/avm_burst_reader.sv
// Avalon burst command register with waitrequest hold and outstanding-word count.
// Command appears 1 cycle after i_issue; held until accepted, read drops the cycle after.
module avm_burst_reader #(
    parameter int ADDR_W  = 32,
    parameter int FIFO_AW = 9
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    pixfifo_fill_ctrl_if.master avm,
    input  logic                i_issue,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [6:0]          i_burst,
    output logic                o_pending,
    output logic                o_accept,
    output logic [6:0]          o_burst,
    output logic [FIFO_AW:0]    o_outstanding
);
    localparam int OW = FIFO_AW + 1;

    logic              r_read;
    logic [ADDR_W-1:0] r_addr;
    logic [6:0]        r_burst;
    logic [OW-1:0]     r_outstanding;
    logic              w_accept;
    logic [OW-1:0]     w_inc;

    assign w_accept = r_read && !avm.avm_waitrequest_i;
    assign w_inc    = OW'(r_burst);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_read        <= 1'b0;
            r_addr        <= '0;
            r_burst       <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_accept) begin
                r_read <= 1'b0;
            end else if (i_issue && !r_read) begin
                r_read  <= 1'b1;
                r_addr  <= i_addr;
                r_burst <= i_burst;
            end
            case ({w_accept, avm.avm_readdatavalid_i})
                2'b10:   r_outstanding <= r_outstanding + w_inc;
                2'b01:   r_outstanding <= r_outstanding - OW'(1);
                2'b11:   r_outstanding <= r_outstanding + w_inc - OW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign avm.avm_read_o       = r_read;
    assign avm.avm_address_o    = r_addr;
    assign avm.avm_burstcount_o = r_burst;
    assign o_pending            = r_read;
    assign o_accept             = w_accept;
    assign o_burst              = r_burst;
    assign o_outstanding        = r_outstanding;
endmodule

// File: rtl/pixfifo_fill_ctrl.sv
// Keeps the HDMI pixel FIFO filled from SDRAM with wrapping frame bursts; FIFO write 1 cycle after readdatavalid.
// Bursts issue only when the FIFO has room for all outstanding words; PIXFIFO_DOUBLE_BUF_EN adds a second base.
module pixfifo_fill_ctrl
    import video_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int BURST_LEN   = 16,
    parameter int FIFO_AW     = 9,
    parameter int FRAME_WORDS = FRAME_WORDS_1080P,
    parameter int PREFILL_LVL = 256
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic [ADDR_W-1:0]   fb_base_i,
`ifdef PIXFIFO_DOUBLE_BUF_EN
    input  logic [ADDR_W-1:0]   fb_base_b_i,
    input  logic                swap_req_i,
    output logic                swap_ack_o,
`endif
    input  logic [FIFO_AW-1:0]  fifo_usedw_i,
    output logic                fifo_wr_o,
    output logic [DATA_W-1:0]   fifo_data_o,
    output logic                fifo_clr_o,
    output logic                pixel_ready_o,
    output logic                underrun_o,
    pixfifo_fill_ctrl_if.master avm
);
    localparam int WR_W  = ($clog2(FRAME_WORDS + 1) > 8) ? $clog2(FRAME_WORDS + 1) : 8;
    localparam int LVL_W = FIFO_AW + 2;
    localparam logic [LVL_W-1:0] ROOM_LIM = LVL_W'((1 << FIFO_AW) - 1);

    fill_state_t       r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [WR_W-1:0]   r_words_req;
    logic              r_clr, r_pix_rdy, r_underrun, r_wr;
    logic [DATA_W-1:0] r_data;

    logic              w_pending, w_accept, w_issue, w_streaming, w_wrap;
    logic [6:0]        w_burst, w_acc_burst;
    logic [FIFO_AW:0]  w_outstanding;
    logic [WR_W-1:0]   w_remain, w_words_sum;
    logic [LVL_W-1:0]  w_need;
    logic [ADDR_W-1:0] w_wrap_base;

    assign w_streaming = (r_state == ST_PREFILL) || (r_state == ST_RUN);
    assign w_remain    = WR_W'(FRAME_WORDS) - r_words_req;
    assign w_burst     = (w_remain < WR_W'(BURST_LEN)) ? w_remain[6:0] : 7'(BURST_LEN);
    assign w_need      = LVL_W'(fifo_usedw_i) + LVL_W'(w_outstanding) + LVL_W'(BURST_LEN);
    assign w_issue     = w_streaming && !w_pending && (w_need <= ROOM_LIM);
    assign w_words_sum = r_words_req + WR_W'(w_acc_burst);
    assign w_wrap      = (w_words_sum == WR_W'(FRAME_WORDS));

`ifdef PIXFIFO_DOUBLE_BUF_EN
    logic r_sel_b, r_swap_pend, r_swap_ack;
    logic w_swap_now, w_next_sel;
    // A request arriving in the wrap cycle itself still swaps at that wrap.
    assign w_swap_now  = r_swap_pend || swap_req_i;
    assign w_next_sel  = r_sel_b ^ w_swap_now;
    assign w_wrap_base = w_next_sel ? fb_base_b_i : fb_base_i;
    assign swap_ack_o  = r_swap_ack;
`else
    assign w_wrap_base = fb_base_i;
`endif

    avm_burst_reader #(
        .ADDR_W (ADDR_W),
        .FIFO_AW(FIFO_AW)
    ) u_rd (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .avm          (avm),
        .i_issue      (w_issue),
        .i_addr       (r_addr),
        .i_burst      (w_burst),
        .o_pending    (w_pending),
        .o_accept     (w_accept),
        .o_burst      (w_acc_burst),
        .o_outstanding(w_outstanding)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_words_req <= '0;
            r_clr       <= 1'b0;
            r_pix_rdy   <= 1'b0;
            r_underrun  <= 1'b0;
            r_wr        <= 1'b0;
            r_data      <= '0;
`ifdef PIXFIFO_DOUBLE_BUF_EN
            r_sel_b     <= 1'b0;
            r_swap_pend <= 1'b0;
            r_swap_ack  <= 1'b0;
`endif
        end else begin
            r_clr <= 1'b0;
            r_wr  <= avm.avm_readdatavalid_i && w_streaming;
            if (avm.avm_readdatavalid_i) begin
                r_data <= avm.avm_readdata_i;
            end
`ifdef PIXFIFO_DOUBLE_BUF_EN
            r_swap_ack <= 1'b0;
            if (swap_req_i) begin
                r_swap_pend <= 1'b1;
            end
`endif
            if (w_accept) begin
                if (w_wrap) begin
                    r_addr      <= w_wrap_base;
                    r_words_req <= '0;
`ifdef PIXFIFO_DOUBLE_BUF_EN
                    r_sel_b     <= w_next_sel;
                    r_swap_ack  <= w_swap_now;
                    r_swap_pend <= 1'b0;
`endif
                end else begin
                    r_addr      <= r_addr + ADDR_W'(w_acc_burst) * ADDR_W'(BYTES_PER_WORD);
                    r_words_req <= w_words_sum;
                end
            end
            if (r_state == ST_RUN && fifo_usedw_i == '0) begin
                r_underrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (enable_i) begin
                        r_state    <= ST_CLEAR;
                        r_clr      <= 1'b1;
                        r_underrun <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    r_addr      <= fb_base_i;
                    r_words_req <= '0;
`ifdef PIXFIFO_DOUBLE_BUF_EN
                    r_sel_b     <= 1'b0;
                    r_swap_pend <= 1'b0;
`endif
                    r_state     <= ST_PREFILL;
                end
                ST_PREFILL: begin
                    if (!enable_i) begin
                        r_state <= ST_DRAIN;
                    end else if (fifo_usedw_i >= FIFO_AW'(PREFILL_LVL)) begin
                        r_state   <= ST_RUN;
                        r_pix_rdy <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!enable_i) begin
                        r_state   <= ST_DRAIN;
                        r_pix_rdy <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // A held command must be accepted and its data returned before leaving.
                    if (w_outstanding == '0 && !w_pending) begin
                        r_state <= ST_IDLE;
                        r_clr   <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign fifo_wr_o     = r_wr;
    assign fifo_data_o   = r_data;
    assign fifo_clr_o    = r_clr;
    assign pixel_ready_o = r_pix_rdy;
    assign underrun_o    = r_underrun;
endmodule
